// File: rtl/mfp_pmod_als_spi_master.sv
// SPI initiator for the PmodALS light sensor (ADC081S021).
// Reads one 16-bit frame, MSB first, and presents the 8-bit light value.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_QUIET | cs high; count QUIET sck falling edges so the sensor reloads
// ST_IDLE  | cs high, not busy; wait for start or auto_en
// ST_ARM   | wait for the next sck rise, then drop cs on that edge
// ST_SHIFT | cs low; sample sdo on each sck rise, 16 samples per frame
module mfp_pmod_als_spi_master #(
   parameter int DIV   = 4,
   parameter int QUIET = 2
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        start,
   input  logic        auto_en,
   output logic        cs,
   output logic        sck,
   input  logic        sdo,
   output logic [7:0]  value,
   output logic [15:0] raw,
   output logic        value_valid,
   output logic        frame_err,
   output logic        busy
);

   localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;

   typedef enum logic [1:0] {ST_QUIET, ST_IDLE, ST_ARM, ST_SHIFT} state_t;

   state_t         state_q, state_d;
   logic [DW-1:0]  div_cnt_q, div_cnt_d;
   logic           sck_q, sck_d;
   logic [QW-1:0]  qcnt_q, qcnt_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [14:0]    shift_q, shift_d;
   logic           cs_q, cs_d;
   logic [15:0]    raw_q, raw_d;
   logic [7:0]     value_q, value_d;
   logic           err_q, err_d;
   logic           valid_q, valid_d;
   logic           div_tc, rise_evt, fall_evt;
   logic [15:0]    frame_word;

   assign div_tc     = (div_cnt_q == DW'(DIV - 1));
   assign rise_evt   = div_tc && !sck_q;
   assign fall_evt   = div_tc && sck_q;
   assign frame_word = {shift_q, sdo};

   // Free-running sck divider: toggles sck every DIV cycles, in every state.
   always_comb begin
      div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
      sck_d     = div_tc ? ~sck_q : sck_q;
   end

   // Frame sequencer: next state, cs, shift register and result capture.
   always_comb begin
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      cs_d      = cs_q;
      raw_d     = raw_q;
      value_d   = value_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      case (state_q)
         ST_QUIET: begin
            cs_d = 1'b1;
            if (fall_evt) begin
               if (qcnt_q == QW'(QUIET - 1)) begin
                  qcnt_d  = '0;
                  state_d = ST_IDLE;
               end else begin
                  qcnt_d = qcnt_q + 1'b1;
               end
            end
         end
         ST_IDLE: begin
            cs_d = 1'b1;
            if (start || auto_en) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (rise_evt) begin
               cs_d      = 1'b0;
               bit_cnt_d = '0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (rise_evt) begin
               shift_d   = frame_word[14:0];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd15) begin
                  cs_d    = 1'b1;
                  raw_d   = frame_word;
                  value_d = frame_word[11:4];
                  err_d   = (frame_word[15:12] != 4'd0) || (frame_word[3:0] != 4'd0);
                  valid_d = 1'b1;
                  state_d = ST_QUIET;
               end
            end
         end
         default: state_d = ST_QUIET;
      endcase
   end

   // sck divider registers.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         div_cnt_q <= '0;
         sck_q     <= 1'b1;
      end else begin
         div_cnt_q <= div_cnt_d;
         sck_q     <= sck_d;
      end
   end

   // Sequencer state and result registers; reset discards any partial frame.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q   <= ST_QUIET;
         qcnt_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         cs_q      <= 1'b1;
         raw_q     <= '0;
         value_q   <= '0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         cs_q      <= cs_d;
         raw_q     <= raw_d;
         value_q   <= value_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
      end
   end

   assign cs          = cs_q;
   assign sck         = sck_q;
   assign raw         = raw_q;
   assign value       = value_q;
   assign frame_err   = err_q;
   assign value_valid = valid_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mfp_pmod_als_spi_master.sv
// Bench for mfp_pmod_als_spi_master with DIV=4, QUIET=2 and a behavioural
// sensor stub that shifts a 16-bit packet out on sck falling edges.
module tb_mfp_pmod_als_spi_master;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        start = 1'b0;
   logic        auto_en = 1'b0;
   logic        sdo = 1'b0;
   logic        cs, sck, value_valid, frame_err, busy;
   logic [7:0]  value;
   logic [15:0] raw;

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] exp_q[$];
   logic [15:0] stub_pkt = 16'h0AB0;
   int          stub_idx = 15;

   mfp_pmod_als_spi_master #(.DIV(4), .QUIET(2)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .auto_en(auto_en),
      .cs(cs), .sck(sck), .sdo(sdo), .value(value), .raw(raw),
      .value_valid(value_valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 HCLK = ~HCLK;

   // Sensor stub: packet restarts when cs falls, next bit after each sck fall.
   always @(negedge cs) stub_idx = 15;
   always @(negedge sck) begin
      if (cs === 1'b0 && stub_idx >= 0) begin
         sdo = stub_pkt[stub_idx];
         stub_idx--;
      end
   end

   // Wait for value_valid (sampled on negedges); start is released after the first edge.
   task automatic wait_valid(input int budget, output bit got, output int cyc, output int cs_low);
      got = 1'b0; cyc = 0; cs_low = 0;
      while (!got && cyc < budget) begin
         @(negedge HCLK);
         start = 1'b0;
         cyc++;
         if (cs === 1'b0) cs_low++;
         if (value_valid === 1'b1) got = 1'b1;
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge HCLK);
         if (busy === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic count_valids(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge HCLK);
         if (value_valid === 1'b1) n++;
      end
   endtask

   task automatic test_reset;
      HRESETn = 1'b0;
      repeat (3) @(negedge HCLK);
      tests_run++; if (cs !== 1'b1) begin tests_failed++; $display("FAIL reset_cs: got %b want 1", cs); end
      tests_run++; if (sck !== 1'b1) begin tests_failed++; $display("FAIL reset_sck: got %b want 1", sck); end
      tests_run++; if (value !== 8'h00) begin tests_failed++; $display("FAIL reset_value: got %h want 00", value); end
      tests_run++; if (raw !== 16'h0000) begin tests_failed++; $display("FAIL reset_raw: got %h want 0000", raw); end
      tests_run++; if (value_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", value_valid); end
      tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", frame_err); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: got %b want 1", busy); end
      HRESETn = 1'b1;
   endtask

   task automatic test_single(input logic [15:0] pkt);
      bit got, ok;
      int cyc, cs_low;
      logic [15:0] e;
      stub_pkt = pkt;
      wait_idle(ok);
      tests_run++; if (!ok || busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle_busy: got %b want 0", busy); end
      exp_q.push_back(pkt);
      start = 1'b1;
      wait_valid(400, got, cyc, cs_low);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      tests_run++;
      if (!got) begin
         tests_failed++; $display("FAIL single_timeout: got no value_valid want pulse (pkt %h)", pkt);
      end else begin
         if (raw !== e) begin tests_failed++; $display("FAIL single_raw: got %h want %h", raw, e); end
         tests_run++; if (value !== e[11:4]) begin tests_failed++; $display("FAIL single_value: got %h want %h", value, e[11:4]); end
         tests_run++; if (frame_err !== ((e[15:12] != 0) || (e[3:0] != 0))) begin
            tests_failed++; $display("FAIL single_err: got %b want %b", frame_err, (e[15:12] != 0) || (e[3:0] != 0)); end
         tests_run++; if (cyc < 129 || cyc > 136) begin tests_failed++; $display("FAIL single_latency: got %0d want 129..136", cyc); end
         tests_run++; if (cs_low != 128) begin tests_failed++; $display("FAIL single_cs_low: got %0d want 128", cs_low); end
         @(negedge HCLK);
         tests_run++; if (value_valid !== 1'b0) begin tests_failed++; $display("FAIL single_pulse_width: got %b want 0", value_valid); end
         tests_run++; if (value !== e[11:4]) begin tests_failed++; $display("FAIL single_value_hold: got %h want %h", value, e[11:4]); end
      end
   endtask

   task automatic test_back_to_back;
      bit got, ok;
      int cyc, cs_low, gap, extra;
      logic [15:0] e;
      stub_pkt = 16'h0AB0;
      wait_idle(ok);
      auto_en = 1'b1;
      for (int f = 0; f < 5; f++) exp_q.push_back(16'h0AB0);
      for (int f = 0; f < 5; f++) begin
         wait_valid(400, got, cyc, cs_low);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
         tests_run++;
         if (!got) begin
            tests_failed++; $display("FAIL auto_timeout: frame %0d got no value_valid", f);
         end else begin
            if (raw !== e || value !== 8'hAB) begin
               tests_failed++; $display("FAIL auto_value: frame %0d got raw %h value %h want %h / AB", f, raw, value, e); end
         end
         if (f < 4) begin
            gap = 0;
            for (int i = 0; i < 100 && cs === 1'b1; i++) begin
               gap++;
               @(negedge HCLK);
            end
            tests_run++; if (gap < 16 || gap > 32) begin tests_failed++; $display("FAIL auto_gap: frame %0d got %0d want 16..32", f, gap); end
            if (f == 3) auto_en = 1'b0;
         end
      end
      count_valids(300, extra);
      tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL auto_stop: got %0d extra frames want 0", extra); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL auto_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_ignored_start;
      bit got, ok;
      int cyc, cs_low, extra;
      logic [15:0] e;
      stub_pkt = 16'h0AB0;
      wait_idle(ok);
      exp_q.push_back(16'h0AB0);
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      repeat (40) @(negedge HCLK);
      tests_run++; if (busy !== 1'b1 || cs !== 1'b0) begin tests_failed++; $display("FAIL ign_shift_busy: got busy %b cs %b want 1 0", busy, cs); end
      start = 1'b1;
      wait_valid(300, got, cyc, cs_low);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      tests_run++;
      if (!got) begin tests_failed++; $display("FAIL ign_timeout: got no value_valid"); end
      else if (raw !== e) begin tests_failed++; $display("FAIL ign_raw: got %h want %h", raw, e); end
      @(negedge HCLK);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ign_quiet_busy: got %b want 1", busy); end
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      count_valids(300, extra);
      tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL ign_extra: got %0d frames want 0", extra); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ign_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_start_and_auto;
      bit got, ok;
      int cyc, cs_low, extra;
      logic [15:0] e;
      stub_pkt = 16'h0AB0;
      wait_idle(ok);
      exp_q.push_back(16'h0AB0);
      start = 1'b1; auto_en = 1'b1;
      @(negedge HCLK);
      start = 1'b0; auto_en = 1'b0;
      wait_valid(300, got, cyc, cs_low);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      tests_run++;
      if (!got) begin tests_failed++; $display("FAIL both_timeout: got no value_valid"); end
      else if (raw !== e) begin tests_failed++; $display("FAIL both_raw: got %h want %h", raw, e); end
      count_valids(300, extra);
      tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL both_extra: got %0d frames want 0", extra); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int extra, w;
      stub_pkt = 16'h0AB0;
      wait_idle(ok);
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      w = 0;
      while (cs !== 1'b0 && w < 50) begin @(negedge HCLK); w++; end
      repeat (60) @(negedge HCLK);
      HRESETn = 1'b0;
      @(negedge HCLK);
      tests_run++; if (cs !== 1'b1 || sck !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pins: got cs %b sck %b want 1 1", cs, sck); end
      tests_run++; if (value !== 8'h00 || raw !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_result: got %h/%h want 00/0000", value, raw); end
      HRESETn = 1'b1;
      count_valids(300, extra);
      tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL rstmid_valid: got %0d pulses want 0", extra); end
   endtask

   initial begin
      test_reset();
      test_single(16'h0AB0);
      test_single(16'h0000);
      test_single(16'h0FF0);
      test_back_to_back();
      test_ignored_start();
      test_start_and_auto();
      test_reset_mid();
      test_single(16'h0AB0);
      test_single(16'h8AB1);
      test_single(16'h0AB0);
      tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
